// File: rtl/fp_mul_seq_if.sv
// Handshake and operand/result bundle for the sequential binary32 multiplier.
// The requester drives start and the operands; the multiplier answers with busy, done and the product.
interface fp_mul_seq_if;
   logic        start;
   logic [31:0] a_bits;
   logic [31:0] b_bits;
   logic        busy;
   logic        done;
   logic [31:0] z_bits;

   modport master (
      output start,
      output a_bits,
      output b_bits,
      input  busy,
      input  done,
      input  z_bits
   );

   modport slave (
      input  start,
      input  a_bits,
      input  b_bits,
      output busy,
      output done,
      output z_bits
   );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754 binary32 multiplier: a 24-step shift-add significand multiply with RNE rounding.
// Subnormal inputs are read as zero and tiny results flush to zero. Latency is a fixed 27 edges.
module fp_mul_seq (
   input  logic        clk,
   input  logic        rst,
   fp_mul_seq_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE,
      UNPACK,
      MULT,
      NORM,
      ROUND
   } state_t;

   state_t             r_state;
   state_t             w_nextState;
   logic               w_busy;

   logic [31:0]        r_aBits;
   logic [31:0]        r_bBits;
   logic [23:0]        r_aMant;
   logic [23:0]        r_bMant;
   logic [47:0]        r_acc;
   logic [4:0]         r_count;
   logic               r_sign;
   logic signed [9:0]  r_exp;
   logic               r_special;
   logic [31:0]        r_specialVal;
   logic [23:0]        r_normMant;
   logic               r_guard;
   logic               r_round;
   logic               r_sticky;
   logic               r_done;
   logic [31:0]        r_z;

   logic [7:0]         w_aExp;
   logic [7:0]         w_bExp;
   logic [22:0]        w_aFrac;
   logic [22:0]        w_bFrac;
   logic               w_aZero;
   logic               w_bZero;
   logic               w_aInf;
   logic               w_bInf;
   logic               w_aNaN;
   logic               w_bNaN;
   logic               w_sign;
   logic [9:0]         w_expSum;

   logic               w_roundUp;
   logic [24:0]        w_mantRnd;
   logic               w_carry;
   logic signed [9:0]  w_expFinal;
   logic [22:0]        w_fracFinal;
   logic [31:0]        w_result;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_busy      = (r_state != IDLE);
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_nextState = UNPACK;
            end
         end
         UNPACK: begin
            w_nextState = MULT;
         end
         MULT: begin
            if (r_count == 5'd23) begin
               w_nextState = NORM;
            end
         end
         NORM: begin
            w_nextState = ROUND;
         end
         ROUND: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Operand classification; an exponent field of zero covers both true zero and subnormals (DAZ).
   always_comb begin
      w_aExp   = r_aBits[30:23];
      w_bExp   = r_bBits[30:23];
      w_aFrac  = r_aBits[22:0];
      w_bFrac  = r_bBits[22:0];
      w_aZero  = (w_aExp == 8'd0);
      w_bZero  = (w_bExp == 8'd0);
      w_aInf   = (w_aExp == 8'hFF) && (w_aFrac == 23'd0);
      w_bInf   = (w_bExp == 8'hFF) && (w_bFrac == 23'd0);
      w_aNaN   = (w_aExp == 8'hFF) && (w_aFrac != 23'd0);
      w_bNaN   = (w_bExp == 8'hFF) && (w_bFrac != 23'd0);
      w_sign   = r_aBits[31] ^ r_bBits[31];
      w_expSum = {2'b00, w_aExp} + {2'b00, w_bExp} - 10'd127;
   end

   always_comb begin
      w_roundUp   = r_guard & (r_round | r_sticky | r_normMant[0]);
      w_mantRnd   = {1'b0, r_normMant} + {24'd0, w_roundUp};
      w_carry     = w_mantRnd[24];
      w_expFinal  = r_exp + $signed({9'd0, w_carry});
      w_fracFinal = w_carry ? w_mantRnd[23:1] : w_mantRnd[22:0];
      w_result    = {r_sign, w_expFinal[7:0], w_fracFinal};
      if (r_special) begin
         w_result = r_specialVal;
      end else if (w_expFinal <= 10'sd0) begin
         w_result = {r_sign, 31'd0};
      end else if (w_expFinal >= 10'sd255) begin
         w_result = {r_sign, 8'hFF, 23'd0};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_aBits      <= 32'd0;
         r_bBits      <= 32'd0;
         r_aMant      <= 24'd0;
         r_bMant      <= 24'd0;
         r_acc        <= 48'd0;
         r_count      <= 5'd0;
         r_sign       <= 1'b0;
         r_exp        <= 10'sd0;
         r_special    <= 1'b0;
         r_specialVal <= 32'd0;
         r_normMant   <= 24'd0;
         r_guard      <= 1'b0;
         r_round      <= 1'b0;
         r_sticky     <= 1'b0;
         r_done       <= 1'b0;
         r_z          <= 32'd0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.start) begin
                  r_aBits <= bus.a_bits;
                  r_bBits <= bus.b_bits;
               end
            end
            UNPACK: begin
               r_aMant   <= w_aZero ? 24'd0 : {1'b1, w_aFrac};
               r_bMant   <= w_bZero ? 24'd0 : {1'b1, w_bFrac};
               r_sign    <= w_sign;
               r_exp     <= $signed(w_expSum);
               r_acc     <= 48'd0;
               r_count   <= 5'd0;
               r_special <= w_aNaN | w_bNaN | w_aInf | w_bInf | w_aZero | w_bZero;
               if (w_aNaN || w_bNaN || (w_aInf && w_bZero) || (w_aZero && w_bInf)) begin
                  r_specialVal <= 32'h7FC00000;
               end else if (w_aInf || w_bInf) begin
                  r_specialVal <= {w_sign, 8'hFF, 23'd0};
               end else begin
                  r_specialVal <= {w_sign, 31'd0};
               end
            end
            MULT: begin
               // Consume b from its MSB so the accumulator only ever shifts left.
               r_acc   <= {r_acc[46:0], 1'b0} + (r_bMant[23] ? {24'd0, r_aMant} : 48'd0);
               r_bMant <= {r_bMant[22:0], 1'b0};
               r_count <= r_count + 5'd1;
            end
            NORM: begin
               if (r_acc[47]) begin
                  r_normMant <= r_acc[47:24];
                  r_guard    <= r_acc[23];
                  r_round    <= r_acc[22];
                  r_sticky   <= |r_acc[21:0];
                  r_exp      <= r_exp + 10'sd1;
               end else begin
                  r_normMant <= r_acc[46:23];
                  r_guard    <= r_acc[22];
                  r_round    <= r_acc[21];
                  r_sticky   <= |r_acc[20:0];
               end
            end
            ROUND: begin
               r_z    <= w_result;
               r_done <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy   = w_busy;
   assign bus.done   = r_done;
   assign bus.z_bits = r_z;

endmodule

// File: doc/fp_mul_seq.md
FP_MUL_SEQ -- requirements
Module: fp_mul_seq

Interface
REQ-001 The block SHALL have no parameters; the operand format is fixed at IEEE-754 binary32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request pulse, accepted only when busy=0.
REQ-005 The block SHALL have port a_bits, input, 32 bits: multiplicand, sampled on the accepting edge.
REQ-006 The block SHALL have port b_bits, input, 32 bits: multiplier, sampled on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse, z_bits valid.
REQ-009 The block SHALL have port z_bits, output, 32 bits: product, held until the next done.

Function
REQ-010 The block SHALL implement the responder side of the start/busy/done handshake: start with busy=0 at edge E0 latches a_bits and b_bits and sets busy=1 after E0.
REQ-011 The block SHALL ignore start while busy=1; operands and the in-flight result are unaffected.
REQ-012 The FSM SHALL use the states IDLE, UNPACK, MULT, NORM, ROUND with these transitions:
  - IDLE->UNPACK on an accepted start
  - UNPACK->MULT, with the iteration counter cleared to 0
  - MULT->MULT while counter<23; MULT->NORM when counter=23
  - NORM->ROUND
  - ROUND->IDLE
REQ-013 MULT SHALL run exactly 24 shift-add iterations, one bit of the 24-bit significand of b per cycle, into a 48-bit accumulator.
REQ-014 Latency SHALL be fixed at 27 edges: the edge E0+27 leaves ROUND, and in the following cycle done=1, busy=0 and z_bits is updated; busy is 1 for exactly 27 cycles.
REQ-015 Latency SHALL be identical for special-case operands (zero, infinity, NaN); the special result overrides the datapath output at ROUND.
REQ-016 A start in the cycle where done=1 SHALL be accepted, allowing back-to-back operations every 28 cycles.
REQ-017 The result sign SHALL be sign(a) XOR sign(b), including for zero and infinity results.
REQ-018 The unbiased exponent SHALL be computed as ea+eb-127 in a signed field of at least 10 bits; if product bit 47 is set, the block SHALL shift right 1 and increment the exponent.
REQ-019 Rounding SHALL be round-to-nearest-even using guard, round and sticky bits; a mantissa carry-out on rounding SHALL renormalize and increment the exponent.
REQ-020 Subnormal inputs SHALL be treated as zero (DAZ).
REQ-021 A biased result exponent of 0 or below after rounding SHALL produce signed zero (FTZ).
REQ-022 A biased result exponent of 255 or above SHALL produce signed infinity (0x7F800000 or 0xFF800000).
REQ-023 A NaN on either input, or infinity times zero, SHALL produce the canonical NaN 0x7FC00000.
REQ-024 Infinity times a nonzero finite value SHALL produce signed infinity; zero times a finite value SHALL produce signed zero.

Reset
REQ-025 While rst=1 the block SHALL drive state=IDLE, busy=0, done=0, z_bits=0x00000000 and counter=0.
REQ-026 rst asserted mid-operation SHALL abort the operation with no done pulse, and the block SHALL accept start on the first edge after rst deasserts.
REQ-027 rst SHALL take priority over start on the same edge.

Verification
REQ-028 0x3FC00000 x 0x40000000 -> done exactly 27 cycles after acceptance, z_bits=0x40400000, busy=1 for exactly 27 cycles.
REQ-029 0xBF800000 x 0x40400000 -> z_bits=0xC0400000.
REQ-030 0x3F800001 x 0x3F800001 -> z_bits=0x3F800002.
REQ-031 Special cases:
  - 0x7F000000 x 0x7F000000 -> 0x7F800000
  - 0x00800000 x 0x3F000000 -> 0x00000000
  - 0x00000000 x 0x7F800000 -> 0x7FC00000
  - 0x7FC00001 x 0x3F800000 -> 0x7FC00000
  - each with done still at 27 cycles
REQ-032 start pulsed with new operands at cycle 10 of an operation -> first result unchanged, exactly one done; a start in the done cycle -> second done 28 cycles after the first.
REQ-033 rst asserted at cycle 15 of an operation -> no done, busy=0 and z_bits=0 after the reset edge, and the next operation is correct.
